// File: rtl/ffs_dispatch_pkg.sv
// Shared types and width helpers for the ffs_dispatch block.
package ffs_dispatch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // Request width actually built: anything below 1 collapses to a single bit.
    function automatic int eff_w(input int w);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_w(input int w);
        return $clog2((w < 2) ? 2 : w);
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ffs_dispatch_if.sv
// Request/offer bundle between event sources, ffs_dispatch and its serial consumer.
interface ffs_dispatch_if #(
    parameter int WIDTH = 8
);
    import ffs_dispatch_pkg::*;

    localparam int W     = eff_w(WIDTH);
    localparam int IDX_W = idx_w(W);

    logic             set_valid;
    logic [W-1:0]     set_mask;
    logic             flush;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic             out_ready;
    logic [W-1:0]     pending;

    // master: sources plus consumer; slave: the dispatcher itself
    modport master (
        output set_valid, set_mask, flush, out_ready,
        input  out_valid, out_index, pending
    );

    modport slave (
        input  set_valid, set_mask, flush, out_ready,
        output out_valid, out_index, pending
    );

endinterface

// File: rtl/ffs_m.sv
// Find-first-set encoder: SIDE=0 picks the highest set bit, SIDE=1 the lowest.
module ffs_m #(
    parameter int  WIDTH = 8,
    parameter bit  SIDE  = 1'b0,
    parameter bit  USE_X = 1'b0,
    localparam int IDX_W = (WIDTH < 2) ? 1 : $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    always_comb begin
        valid_o = |vec_i;
        index_o = USE_X ? {IDX_W{1'bx}} : '0;
        // Scan away from the priority end so the last hit is the winner.
        if (SIDE) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (vec_i[i]) index_o = IDX_W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (vec_i[i]) index_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ffs_dispatch.sv
// Pending-event dispatcher: collects request bits, offers one index at a time.
// Optional FFS_DISPATCH_COUNT_EN adds pending_count and merge_pulse outputs.
module ffs_dispatch
    import ffs_dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SIDE  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    ffs_dispatch_if.slave bus
`ifdef FFS_DISPATCH_COUNT_EN
    ,
    output logic [cnt_w(eff_w(WIDTH))-1:0] pending_count,
    output logic                           merge_pulse
`endif
);

    localparam int W     = eff_w(WIDTH);
    localparam int IDX_W = idx_w(W);

    state_e           state_q, state_d;
    logic [W-1:0]     pend_q, pend_d;
    logic [W-1:0]     keep, clr, onehot_idx;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid, fire;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_index;

    assign out_valid = (state_q == OFFER);
    assign fire      = out_valid & bus.out_ready;

    always_comb begin
        onehot_idx = W'(1) << idx_q;
        clr        = fire ? onehot_idx : '0;
        // Flush never drops a bit that is still on offer.
        keep       = bus.flush ? ((out_valid & ~fire) ? onehot_idx : '0) : pend_q;
        pend_d     = (keep & ~clr) | (bus.set_valid ? bus.set_mask : '0);
    end

    ffs_m #(
        .WIDTH (W),
        .SIDE  (SIDE),
        .USE_X (1'b0)
    ) u_ffs (
        .vec_i   (pend_d),
        .valid_o (sel_valid),
        .index_o (sel_index)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = OFFER;
                    idx_d   = sel_index;
                end
            end
            OFFER: begin
                // Without ready the offer is frozen, even against higher priority arrivals.
                if (bus.out_ready) begin
                    if (sel_valid) begin
                        idx_d = sel_index;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_index = idx_q;
    assign bus.pending   = pend_q;

`ifdef FFS_DISPATCH_COUNT_EN
    localparam int CW = cnt_w(W);

    logic [CW-1:0] cnt_q;
    logic          merge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            merge_q <= 1'b0;
        end else begin
            cnt_q   <= CW'($countones(pend_d));
            merge_q <= bus.set_valid & (|(bus.set_mask & keep & ~clr));
        end
    end

    assign pending_count = cnt_q;
    assign merge_pulse   = merge_q;
`else
    // Plain build: no occupancy or merge tracking.
`endif

endmodule

// File: tb/tb_ffs_dispatch.sv
// Bench for ffs_dispatch: two instances (SIDE=0 and SIDE=1) share one stimulus stream.
module tb_ffs_dispatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sv, fl, rdy;
    logic [7:0] sm;
    logic       chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    ffs_dispatch_if #(.WIDTH(8)) bus0 ();
    ffs_dispatch_if #(.WIDTH(8)) bus1 ();

    assign bus0.set_valid = sv;  assign bus1.set_valid = sv;
    assign bus0.set_mask  = sm;  assign bus1.set_mask  = sm;
    assign bus0.flush     = fl;  assign bus1.flush     = fl;
    assign bus0.out_ready = rdy; assign bus1.out_ready = rdy;

`ifdef FFS_DISPATCH_COUNT_EN
    logic [3:0] cnt0, cnt1;
    logic       mrg0, mrg1;
`endif

    ffs_dispatch #(.WIDTH(8), .SIDE(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef FFS_DISPATCH_COUNT_EN
        , .pending_count (cnt0), .merge_pulse (mrg0)
`endif
    );

    ffs_dispatch #(.WIDTH(8), .SIDE(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef FFS_DISPATCH_COUNT_EN
        , .pending_count (cnt1), .merge_pulse (mrg1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input logic [7:0] p, input int side);
        if (side == 0) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] bit8(input int i);
        return 8'h01 << i;
    endfunction

    logic [7:0] m_p [2], nx_p [2], mk [2];
    logic       m_v [2], nx_v [2], mf [2];
    int         m_i [2], nx_i [2];
    logic       m_mrg [2], nx_mrg [2];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            mf[s]     = m_v[s] && rdy;
            mk[s]     = fl ? ((m_v[s] && !mf[s]) ? bit8(m_i[s]) : 8'h00) : m_p[s];
            if (mf[s]) mk[s] = mk[s] & ~bit8(m_i[s]);
            nx_mrg[s] = sv && ((sm & mk[s]) != 8'h00);
            nx_p[s]   = mk[s] | (sv ? sm : 8'h00);
            nx_v[s]   = m_v[s];
            nx_i[s]   = m_i[s];
            if (!(m_v[s] && !rdy)) begin
                nx_v[s] = (nx_p[s] != 8'h00);
                nx_i[s] = (nx_p[s] != 8'h00) ? pick(nx_p[s], s) : 0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                m_p[s] <= 8'h00; m_v[s] <= 1'b0; m_i[s] <= 0; m_mrg[s] <= 1'b0;
            end else begin
                m_p[s] <= nx_p[s]; m_v[s] <= nx_v[s]; m_i[s] <= nx_i[s]; m_mrg[s] <= nx_mrg[s];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("m0_valid", int'(bus0.out_valid), int'(m_v[0]));
            check("m0_index", int'(bus0.out_index), m_i[0]);
            check("m0_pend",  int'(bus0.pending),   int'(m_p[0]));
            check("m1_valid", int'(bus1.out_valid), int'(m_v[1]));
            check("m1_index", int'(bus1.out_index), m_i[1]);
            check("m1_pend",  int'(bus1.pending),   int'(m_p[1]));
`ifdef FFS_DISPATCH_COUNT_EN
            check("m0_cnt",   int'(cnt0), $countones(m_p[0]));
            check("m1_cnt",   int'(cnt1), $countones(m_p[1]));
            check("m0_merge", int'(mrg0), int'(m_mrg[0]));
            check("m1_merge", int'(mrg1), int'(m_mrg[1]));
`endif
        end
    end

    task automatic cyc(input logic v, input logic [7:0] m, input logic f, input logic r);
        sv = v; sm = m; fl = f; rdy = r;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int v0, input int i0, input int p0,
                       input int v1, input int i1, input int p1);
        check({name, "_v0"}, int'(bus0.out_valid), v0);
        if (v0 != 0) check({name, "_i0"}, int'(bus0.out_index), i0);
        check({name, "_p0"}, int'(bus0.pending), p0);
        check({name, "_v1"}, int'(bus1.out_valid), v1);
        if (v1 != 0) check({name, "_i1"}, int'(bus1.out_index), i1);
        check({name, "_p1"}, int'(bus1.pending), p1);
    endtask

    initial begin
        sv = 1'b0; sm = 8'h00; fl = 1'b0; rdy = 1'b0;
        chk_en = 1'b1;

        // Reset held across random set pulses
        repeat (4) begin
            sv = 1'b1; sm = 8'($urandom);
            @(negedge clk);
            lit("rst", 0, 0, 8'h00, 0, 0, 8'h00);
        end
        sv = 1'b0; sm = 8'h00; rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);
        lit("idle", 0, 0, 8'h00, 0, 0, 8'h00);

        // Drain 0xA4 with ready high
        cyc(1, 8'hA4, 0, 1); lit("drain1", 1, 7, 8'hA4, 1, 2, 8'hA4);
        cyc(0, 8'h00, 0, 1); lit("drain2", 1, 5, 8'h24, 1, 5, 8'hA0);
        cyc(0, 8'h00, 0, 1); lit("drain3", 1, 2, 8'h04, 1, 7, 8'h80);
        cyc(0, 8'h00, 0, 1); lit("drain4", 0, 0, 8'h00, 0, 0, 8'h00);

        // Backpressure: offer of index 0 is frozen while 0x80 arrives
        cyc(1, 8'h01, 0, 0); lit("bp1", 1, 0, 8'h01, 1, 0, 8'h01);
        cyc(1, 8'h80, 0, 0); lit("bp2", 1, 0, 8'h81, 1, 0, 8'h81);
        cyc(0, 8'h00, 0, 0); lit("bp3", 1, 0, 8'h81, 1, 0, 8'h81);
        cyc(0, 8'h00, 0, 1); lit("bp4", 1, 7, 8'h80, 1, 7, 8'h80);
        cyc(0, 8'h00, 0, 1); lit("bp5", 0, 0, 8'h00, 0, 0, 8'h00);

        // Re-arm the bit being accepted
        cyc(1, 8'h08, 0, 1); lit("rearm1", 1, 3, 8'h08, 1, 3, 8'h08);
        cyc(1, 8'h08, 0, 1); lit("rearm2", 1, 3, 8'h08, 1, 3, 8'h08);
        cyc(0, 8'h00, 0, 1); lit("rearm3", 0, 0, 8'h00, 0, 0, 8'h00);

        // Flush while holding an offer, with a simultaneous set
        cyc(1, 8'h31, 0, 0); lit("flush1", 1, 5, 8'h31, 1, 0, 8'h31);
`ifdef FFS_DISPATCH_COUNT_EN
        check("flush1_cnt", int'(cnt0), 3);
`endif
        cyc(1, 8'h02, 1, 0); lit("flush2", 1, 5, 8'h22, 1, 0, 8'h03);
`ifdef FFS_DISPATCH_COUNT_EN
        check("flush2_cnt", int'(cnt0), 2);
`endif
        cyc(0, 8'h00, 0, 1); lit("flush3", 1, 1, 8'h02, 1, 1, 8'h02);
`ifdef FFS_DISPATCH_COUNT_EN
        check("flush3_cnt", int'(cnt0), 1);
`endif
        cyc(0, 8'h00, 0, 1); lit("flush4", 0, 0, 8'h00, 0, 0, 8'h00);
`ifdef FFS_DISPATCH_COUNT_EN
        check("flush4_cnt", int'(cnt0), 0);
`endif

        // Async reset in the middle of an offer
        cyc(1, 8'h10, 0, 0); lit("areset0", 1, 4, 8'h10, 1, 4, 8'h10);
        sv = 1'b0; sm = 8'h00;
        #2 rst_n = 1'b0;
        #1 lit("areset1", 0, 0, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 1); lit("areset2", 0, 0, 8'h00, 0, 0, 8'h00);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ffs_dispatch.md
Name: ffs_dispatch

Overview:
- Sequential consumer of the find-first-set encoder (ffs_m).
- Accumulates one-hot/multi-hot event requests into a pending register and selects the highest-priority pending bit with ffs_m.
- Presents the selected bit as an index on a valid/ready output port and clears that bit on handshake.
- Sits between event sources (interrupt lines, completion flags) and a single serial consumer.

Parameters:
- WIDTH, 8, number of request bits; values below 1 are treated as 1.
- SIDE, 1'b0, priority order passed to ffs_m: 0 = MSB has priority, 1 = LSB has priority.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- set_valid  input  1  qualifies set_mask this cycle.
- set_mask  input  WIDTH  bits to OR into pending.
- flush  input  1  synchronous clear of all pending bits except the bit currently offered.
- out_valid  output  1  an index is offered.
- out_index  output  IDX_W  offered bit position; IDX_W = clog2(max(WIDTH,2)).
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid & out_ready.
- pending  output  WIDTH  registered pending vector, including the offered bit.

Behaviour:
- Reset (rst_n low): pending=0, out_valid=0, out_index=0, state IDLE, all registers cleared at once; an offer in progress is dropped.
- fire = out_valid & out_ready; clr = fire ? onehot(out_index) : 0.
- pending_next = ((flush ? (out_valid & !fire ? onehot(out_index) : 0) : pending) & ~clr) | (set_valid ? set_mask : 0).
- Set wins over clear and over flush for the same bit; a re-armed bit can be reselected on the next cycle.
- Selection: ffs_m on pending_next gives sel_valid and sel_index.
- States:
  - IDLE: out_valid=0. If sel_valid, go to OFFER and load out_index=sel_index.
  - OFFER: out_valid=1.
    - If !out_ready, hold out_index stable, even if a higher-priority bit arrives.
    - If fire and sel_valid, stay in OFFER and load the new sel_index.
    - If fire and !sel_valid, go to IDLE.
- Latency: set_mask sampled at edge N gives out_valid high after edge N (one cycle, registered output).
- Throughput: one index per cycle while out_ready=1.
- While out_valid=1, pending[out_index] is always 1.
- out_index is don't-care when out_valid=0; it is driven to 0 in IDLE.
- All-zero set_mask with set_valid=1 has no effect.
- Indices are zero-based (bit 0 = index 0), the same as ffs_m output.

Optional Feature:
- Macro FFS_DISPATCH_COUNT_EN.
- With the macro defined:
  - Adds output pending_count, width clog2(WIDTH+1), registered, equal to popcount(pending) and updated in the same cycle as pending.
  - Adds output merge_pulse, 1 bit, registered, high for one cycle when set_mask hit a bit already pending and not cleared that cycle.
- Without the macro: neither port exists and no counter logic is built.

Decomposition:
- Package ffs_dispatch_pkg:
  - state enum {IDLE, OFFER};
  - index-width helper function (clog2 clamped to a minimum of 2 inputs);
  - count-width helper.
- Sub-module: one instance of the existing ffs_m (USE_X=0, SIDE passed through) on pending_next.
- No other sub-modules.

Test Plan (WIDTH=8):
- Reset: hold rst_n=0 across random set pulses -> out_valid=0, pending=0x00. Assert rst_n=0 mid-OFFER -> out_valid falls immediately without waiting for a clock.
- Drain, SIDE=0: set 0xA4 at cycle 0 with out_ready=1 -> out_index 7, 5, 2 on cycles 1, 2, 3 with out_valid=1; cycle 4 out_valid=0, pending=0x00.
- Drain, SIDE=1: same stimulus -> indices 2, 5, 7.
- Backpressure: set 0x01 with out_ready=0, then set 0x80 next cycle -> out_index stays 0 for 3 cycles. Raise out_ready -> next index is 7, pending=0x00 after it.
- Re-arm: offering index 3 with out_ready=1, and set_mask=0x08 in the same cycle -> next cycle out_index=3, out_valid=1, pending=0x08.
- Flush: pending=0x31, offering 5, out_ready=0, flush=1 with set 0x02 -> pending=0x22, out_index holds 5. After accept -> index 1, then IDLE.
  - With FFS_DISPATCH_COUNT_EN: pending_count reads 3 -> 2 -> 1 -> 0.
